// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch port and a data port onto
// one shared single-port memory with variable completion latency.
// Data requests win unless they have taken MAX_DM_STREAK consecutive grants
// while a fetch is waiting. Completion data is registered and flagged with a
// one-cycle Valid pulse.
// Optional build macro ARB_TIMEOUT_EN adds an 8-bit transfer watchdog that
// aborts a stuck transfer (zero data, sticky Error); otherwise Error is 0.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic [31:0] IF_Data,
  output logic        IF_Valid,
  input  logic        DM_Req,
  input  logic        DM_Write,
  input  logic [31:0] DM_Addr,
  input  logic [31:0] DM_WData,
  input  logic [1:0]  DM_ByteSel,
  output logic [31:0] DM_RData,
  output logic        DM_Valid,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [1:0]  Mem_ByteSel,
  input  logic [31:0] Mem_RData,
  input  logic        Mem_Ready,
  output logic        Stall,
  output logic        Error
);

  typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_DM_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] lat_addr_q, lat_wdata_q;
  logic        lat_write_q;
  logic [1:0]  lat_bsel_q;
  logic [31:0] if_data_q, dm_rdata_q;
  logic        if_valid_q, dm_valid_q;
  logic        if_pend, dm_pend, turnaround, xfer, done, abort;
  logic        grant_if, grant_dm;
  logic [31:0] cap_data;

  // A requester is not pending in its own Valid cycle (it is dropping Req).
  assign if_pend    = IF_Req & ~if_valid_q;
  assign dm_pend    = DM_Req & ~dm_valid_q;
  // Completion cycles are a turnaround: no new grant, so a requester that
  // re-raises Req right after its Valid competes on equal terms next cycle.
  assign turnaround = if_valid_q | dm_valid_q;
  assign xfer       = (state_q != IDLE);
  assign done       = xfer & (Mem_Ready | abort);
  assign cap_data   = Mem_Ready ? Mem_RData : '0;

  // Next-state, grant decision and streak update.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!turnaround) begin
          if (dm_pend && ((streak_q < MAX_S) || !if_pend)) begin
            grant_dm = 1'b1;
            state_d  = DM_XFER;
            if (if_pend)
              streak_d = (streak_q < MAX_S) ? streak_q + 4'd1 : streak_q;
            else
              streak_d = '0;
          end else if (if_pend) begin
            grant_if = 1'b1;
            state_d  = IF_XFER;
            streak_d = '0;
          end
        end
      end
      IF_XFER, DM_XFER: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, streak and latched request registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_write_q <= 1'b0;
      lat_bsel_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (grant_dm) begin
        lat_addr_q  <= DM_Addr;
        lat_wdata_q <= DM_WData;
        lat_write_q <= DM_Write;
        lat_bsel_q  <= DM_ByteSel;
      end else if (grant_if) begin
        lat_addr_q  <= IF_Addr;
        lat_wdata_q <= '0;
        lat_write_q <= 1'b0;
        lat_bsel_q  <= '0;
      end
    end
  end

  // Completion capture and Valid pulses; stores leave DM_RData untouched.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      if_valid_q <= done && (state_q == IF_XFER);
      dm_valid_q <= done && (state_q == DM_XFER);
      if (done && (state_q == IF_XFER))
        if_data_q <= cap_data;
      if (done && (state_q == DM_XFER) && !lat_write_q)
        dm_rdata_q <= cap_data;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       error_q;

  // wd_q is 0 in the first XFER cycle, so aborting at 254 ends the transfer
  // after 255 cycles without Mem_Ready.
  assign abort = xfer && !Mem_Ready && (wd_q == 8'd254);
  assign Error = error_q;

  // Watchdog counter and sticky error flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (grant_if || grant_dm)
        wd_q <= '0;
      else if (xfer)
        wd_q <= wd_q + 8'd1;
      if (abort)
        error_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign Error = 1'b0;
`endif

  assign IF_Data     = if_data_q;
  assign IF_Valid    = if_valid_q;
  assign DM_RData    = dm_rdata_q;
  assign DM_Valid    = dm_valid_q;
  assign Mem_Req     = xfer;
  assign Mem_Write   = (state_q == DM_XFER) & lat_write_q;
  assign Mem_Addr    = xfer ? lat_addr_q  : '0;
  assign Mem_WData   = xfer ? lat_wdata_q : '0;
  assign Mem_ByteSel = xfer ? lat_bsel_q  : '0;
  assign Stall       = if_pend | dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model. The watchdog
// scenario is compiled only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Addr = '0;
  logic [31:0] IF_Data;
  logic        IF_Valid;
  logic        DM_Req = 1'b0;
  logic        DM_Write = 1'b0;
  logic [31:0] DM_Addr = '0;
  logic [31:0] DM_WData = '0;
  logic [1:0]  DM_ByteSel = '0;
  logic [31:0] DM_RData;
  logic        DM_Valid;
  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [1:0]  Mem_ByteSel;
  logic [31:0] Mem_RData = '0;
  logic        Mem_Ready = 1'b0;
  logic        Stall;
  logic        Error;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_DM_STREAK(MAX)) dut (
    .Clock(Clock), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Data(IF_Data), .IF_Valid(IF_Valid),
    .DM_Req(DM_Req), .DM_Write(DM_Write), .DM_Addr(DM_Addr), .DM_WData(DM_WData),
    .DM_ByteSel(DM_ByteSel), .DM_RData(DM_RData), .DM_Valid(DM_Valid),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_ByteSel(Mem_ByteSel), .Mem_RData(Mem_RData),
    .Mem_Ready(Mem_Ready), .Stall(Stall), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic do_reset();
    Reset = 1'b1; IF_Req = 1'b0; DM_Req = 1'b0; Mem_Ready = 1'b0;
    DM_Write = 1'b0; Mem_RData = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_if_data"}, IF_Data, 0);
    check_val({tag, "_if_valid"}, IF_Valid, 0);
    check_val({tag, "_dm_rdata"}, DM_RData, 0);
    check_val({tag, "_dm_valid"}, DM_Valid, 0);
    check_val({tag, "_mem_req"}, Mem_Req, 0);
    check_val({tag, "_mem_write"}, Mem_Write, 0);
    check_val({tag, "_mem_addr"}, Mem_Addr, 0);
    check_val({tag, "_mem_wdata"}, Mem_WData, 0);
    check_val({tag, "_mem_bsel"}, Mem_ByteSel, 0);
    check_val({tag, "_error"}, Error, 0);
  endtask

  // One complete transfer from an idle arbiter; lat = number of Mem_Req cycles.
  task automatic run_xfer(input bit is_dm, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] bsel,
                          input logic [31:0] rdata, input int lat,
                          input logic [31:0] exp_data);
    int stall_n = 0;
    step();
    check_val("idle_mem_req", Mem_Req, 0);
    if (is_dm) begin
      DM_Req = 1'b1; DM_Write = wr; DM_Addr = addr; DM_WData = wdata; DM_ByteSel = bsel;
    end else begin
      IF_Req = 1'b1; IF_Addr = addr;
    end
    Mem_Ready = 1'b0;
    #1 if (Stall) stall_n++;
    for (int i = 1; i <= lat; i++) begin
      step();
      check_val("xfer_mem_req", Mem_Req, 1);
      check_val("xfer_mem_addr", Mem_Addr, addr);
      check_val("xfer_mem_write", Mem_Write, is_dm & wr);
      if (is_dm) begin
        check_val("xfer_mem_wdata", Mem_WData, wdata);
        check_val("xfer_mem_bsel", Mem_ByteSel, bsel);
      end
      check_val("xfer_no_valid", is_dm ? DM_Valid : IF_Valid, 0);
      Mem_Ready = (i == lat);
      Mem_RData = rdata;
      #1 if (Stall) stall_n++;
    end
    step();
    check_val("valid_pulse", is_dm ? DM_Valid : IF_Valid, 1);
    check_val("other_valid", is_dm ? IF_Valid : DM_Valid, 0);
    check_val("data_out", is_dm ? DM_RData : IF_Data, exp_data);
    check_val("idle_after", Mem_Req, 0);
    IF_Req = 1'b0; DM_Req = 1'b0; Mem_Ready = 1'b0;
    #1 if (Stall) stall_n++;
    step();
    check_val("valid_one_cycle", is_dm ? DM_Valid : IF_Valid, 0);
    check_val("data_hold", is_dm ? DM_RData : IF_Data, exp_data);
    check_val("stall_cycles", stall_n, lat + 1);
  endtask

  task automatic grant_order();
    bit got_g[6];
    int exp_g[6] = '{1, 1, 1, 1, 0, 1};
    int n = 0;
    bit prev = 1'b0;
    IF_Addr = 32'h1000_0040; DM_Addr = 32'h2000_0080; DM_Write = 1'b0;
    Mem_RData = 32'h1234_5678;
    IF_Req = 1'b1; DM_Req = 1'b1; Mem_Ready = 1'b0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      step();
      if (Mem_Req && !prev) begin
        got_g[n] = (Mem_Addr == 32'h2000_0080);
        n++;
      end
      prev = Mem_Req;
      Mem_Ready = Mem_Req;
      IF_Req = ~IF_Valid;
      DM_Req = ~DM_Valid;
    end
    check_val("grant_count", n, 6);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("grant_%0d_is_dm", i), got_g[i], exp_g[i]);
    IF_Req = 1'b0; DM_Req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      Mem_Ready = Mem_Req;
    end
  endtask

  task automatic random_phase(input int cycles);
    bit ip = 0, dp = 0, dwr = 0;
    logic [31:0] ia = '0, da = '0, dw = '0;
    logic [1:0] db = '0;
    int igap = 0, dgap = 0, left = 0, streak = 0;
    bit busy = 0, own_dm = 0, ev_if = 0, ev_dm = 0;
    bit n_busy, n_ev_if, n_ev_dm;
    logic [31:0] if_last = '0, dm_last = '0;
    for (int c = 0; c < cycles; c++) begin
      step();
      check_val("rnd_if_valid", IF_Valid, ev_if);
      check_val("rnd_dm_valid", DM_Valid, ev_dm);
      check_val("rnd_if_data", IF_Data, if_last);
      check_val("rnd_dm_rdata", DM_RData, dm_last);
      check_val("rnd_mem_req", Mem_Req, busy);
      if (busy) begin
        check_val("rnd_mem_addr", Mem_Addr, own_dm ? da : ia);
        check_val("rnd_mem_write", Mem_Write, own_dm & dwr);
        if (own_dm) begin
          check_val("rnd_mem_wdata", Mem_WData, dw);
          check_val("rnd_mem_bsel", Mem_ByteSel, db);
        end
      end
      // requesters: drop in the Valid cycle, then a random gap
      if (ev_if) begin
        ip = 0; igap = $urandom_range(0, 3);
      end else if (!ip) begin
        if (igap > 0) igap--;
        else if ($urandom_range(0, 1) == 1) begin
          ip = 1; ia = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
        end
      end
      if (ev_dm) begin
        dp = 0; dgap = $urandom_range(0, 3);
      end else if (!dp) begin
        if (dgap > 0) dgap--;
        else if ($urandom_range(0, 2) != 0) begin
          dp = 1; dwr = $urandom_range(0, 1);
          da = (dwr ? 32'h3000_0000 : 32'h2000_0000) | ($urandom & 32'h0000_FFFC);
          dw = $urandom; db = 2'($urandom_range(0, 3));
        end
      end
      // memory side
      n_busy = busy; n_ev_if = 0; n_ev_dm = 0;
      Mem_Ready = 1'b0; Mem_RData = $urandom;
      if (busy) begin
        left--;
        if (left == 0) begin
          Mem_Ready = 1'b1; n_busy = 0;
          if (own_dm) begin
            n_ev_dm = 1;
            if (!dwr) begin Mem_RData = hash(Mem_Addr); dm_last = hash(da); end
          end else begin
            n_ev_if = 1; Mem_RData = hash(Mem_Addr); if_last = hash(ia);
          end
        end
      end else begin
        Mem_Ready = ($urandom_range(0, 1) == 1);
      end
      // arbitration rule: DM first unless its streak is exhausted with IF waiting
      if (!busy && !ev_if && !ev_dm && (ip || dp)) begin
        if (dp && (streak < MAX || !ip)) begin
          own_dm = 1;
          streak = ip ? ((streak < MAX) ? streak + 1 : streak) : 0;
        end else begin
          own_dm = 0; streak = 0;
        end
        n_busy = 1; left = $urandom_range(1, 4);
      end
      IF_Req = ip; IF_Addr = ia;
      DM_Req = dp; DM_Write = dwr; DM_Addr = da; DM_WData = dw; DM_ByteSel = db;
      #1 check_val("rnd_stall", Stall, (ip & ~ev_if) | (dp & ~ev_dm));
      busy = n_busy; ev_if = n_ev_if; ev_dm = n_ev_dm;
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic timeout_test();
    int mreq = 0;
    bit seen = 0;
    do_reset();
    run_xfer(0, 0, 32'h44, '0, '0, 32'h1111_2222, 1, 32'h1111_2222);
    step();
    IF_Req = 1'b1; IF_Addr = 32'h80; Mem_Ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (Mem_Req) mreq++;
      if (IF_Valid) begin seen = 1; break; end
    end
    check_val("wd_valid_seen", seen, 1);
    check_val("wd_xfer_cycles", mreq, 255);
    check_val("wd_if_data", IF_Data, 0);
    check_val("wd_error_set", Error, 1);
    IF_Req = 1'b0;
    run_xfer(0, 0, 32'h88, '0, '0, 32'h3333_4444, 2, 32'h3333_4444);
    check_val("wd_error_sticky", Error, 1);
    do_reset();
    check_val("wd_error_cleared", Error, 0);
  endtask
`endif

  initial begin
    do_reset();
    check_outputs_zero("reset");
    check_val("reset_stall", Stall, 0);

    // Mem_Ready while idle must be ignored
    Mem_Ready = 1'b1; Mem_RData = 32'hFFFF_FFFF;
    step();
    step();
    check_val("idle_ready_if_valid", IF_Valid, 0);
    check_val("idle_ready_dm_valid", DM_Valid, 0);
    check_val("idle_ready_mem_req", Mem_Req, 0);
    check_val("idle_ready_if_data", IF_Data, 0);

    // fetch with Mem_Ready two cycles after Mem_Req rises
    run_xfer(0, 0, 32'h40, '0, '0, 32'h2008_000A, 3, 32'h2008_000A);

    // load to give DM_RData a known value, then a store that must keep it
    run_xfer(1, 0, 32'h2000_0200, '0, 2'b10, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);
    run_xfer(1, 1, 32'h100, 32'hDEAD_BEEF, 2'b00, 32'hFFFF_FFFF, 1, 32'h0BAD_F00D);

    // reset in the middle of a data transfer
    step();
    DM_Req = 1'b1; DM_Write = 1'b0; DM_Addr = 32'h2000_0300; Mem_Ready = 1'b0;
    step();
    check_val("rst_mid_mem_req", Mem_Req, 1);
    step();
    Reset = 1'b1;
    step();
    check_outputs_zero("rst_mid");
    Reset = 1'b0; DM_Req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("rst_mid_no_valid", DM_Valid, 0);
      check_val("rst_mid_idle", Mem_Req, 0);
    end

    do_reset();
    grant_order();

    do_reset();
    random_phase(3000);

`ifdef ARB_TIMEOUT_EN
    timeout_test();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL expose parameter MAX_DM_STREAK, default 4, max consecutive DM grants while IF_Req is pending (range 1..15).
REQ-002 The block SHALL expose the following ports, one per line (name, direction, width, meaning):
  Clock  in  1  single clock; all state updates on rising edge
  Reset  in  1  synchronous, active-high reset
  IF_Req  in  1  fetch request, held until IF_Valid
  IF_Addr  in  32  fetch byte address
  IF_Data  out  32  fetched instruction, registered
  IF_Valid  out  1  one-cycle fetch-complete pulse
  DM_Req  in  1  data request, held until DM_Valid
  DM_Write  in  1  1 = store, 0 = load
  DM_Addr  in  32  data byte address
  DM_WData  in  32  store data
  DM_ByteSel  in  2  access size, passed through unchanged
  DM_RData  out  32  load data, registered
  DM_Valid  out  1  one-cycle data-complete pulse (loads and stores)
  Mem_Req  out  1  shared single-port memory request
  Mem_Write  out  1  shared memory write strobe
  Mem_Addr  out  32  shared memory address
  Mem_WData  out  32  shared memory write data
  Mem_ByteSel  out  2  shared memory access size
  Mem_RData  in  32  shared memory read data, valid with Mem_Ready
  Mem_Ready  in  1  shared memory completion, variable latency >= 1 cycle
  Stall  out  1  pipeline freeze, combinational
  Error  out  1  sticky watchdog error flag
REQ-003 Clock and reset SHALL be one clock; reset is synchronous and active-high, with ports named Clock and Reset.

Function
REQ-004 The FSM SHALL have three states: IDLE, IF_XFER, DM_XFER.
REQ-005 In IDLE, a pending DM_Req SHALL win when streak < MAX_DM_STREAK or IF_Req is low; otherwise a pending IF_Req wins; with no request, the FSM stays in IDLE.
REQ-006 On grant, the winner's address, write flag, wdata and ByteSel SHALL be latched, and the XFER state is entered next cycle.
REQ-007 During XFER, Mem_Req SHALL be 1 and Mem_* SHALL be driven from the latched registers only. Mem_Write SHALL be 1 only in DM_XFER for stores. Mem_* SHALL be 0 in IDLE.
REQ-008 On the Mem_Ready cycle in XFER, Mem_RData SHALL be captured into IF_Data (IF_XFER) or DM_RData (DM_XFER load), the matching Valid SHALL pulse on the next cycle, and the state returns to IDLE.
REQ-009 Latency SHALL be: request seen in IDLE at cycle T; Mem_Req high at T+1; Mem_Ready at T+k; Valid at T+k+1.
REQ-010 DM_RData SHALL hold its value on store completion. Each data output SHALL hold until its next completion.
REQ-011 In a Valid-pulse cycle, the arbiter SHALL ignore that requester's Req; the requester drops Req in that cycle.
REQ-012 The streak counter SHALL:
  - increment (saturating at MAX_DM_STREAK) on a DM grant while IF_Req = 1;
  - clear on an IF grant;
  - clear on a DM grant while IF_Req = 0.
REQ-013 Mem_Ready in IDLE SHALL be ignored.
REQ-014 Req changes during XFER SHALL NOT affect the transfer in flight.
REQ-015 Stall SHALL = (IF_Req & ~IF_Valid) | (DM_Req & ~DM_Valid).

Reset
REQ-016 On a clock edge with Reset = 1, the block SHALL enter the following state:
  - state IDLE;
  - streak 0;
  - all outputs 0, including IF_Data, DM_RData, Valids, Mem_* and Error.
REQ-017 Reset mid-XFER SHALL abandon the transfer with no Valid pulse; Mem_Req SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-018 With ARB_TIMEOUT_EN defined, an 8-bit watchdog SHALL behave as follows:
  - it counts cycles in XFER and clears on entering XFER;
  - on reaching 255 without Mem_Ready, the transfer aborts to IDLE;
  - the matching Valid pulses with data 32'h0000_0000;
  - Error sets and stays set until Reset.
REQ-019 Without ARB_TIMEOUT_EN, no watchdog SHALL be present, Error is tied 0, and XFER waits indefinitely.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - IF_Req alone, IF_Addr = 0x40, Mem_Ready 2 cycles after Mem_Req, Mem_RData = 0x2008000A -> IF_Valid 1 cycle, IF_Data = 0x2008000A, Stall high for 4 cycles.
  - IF_Req and DM_Req both held, MAX_DM_STREAK = 4 -> grant order DM, DM, DM, DM, IF, DM.
  - DM store, addr 0x100, wdata 0xDEADBEEF, ByteSel 2'b00 -> Mem_Write = 1 with matching Mem_Addr/Mem_WData; DM_Valid pulses; DM_RData unchanged.
  - Reset asserted during DM_XFER -> Mem_Req 0 next cycle, no DM_Valid, state IDLE, outputs 0.
  - ARB_TIMEOUT_EN defined, Mem_Ready never asserted -> after 255 XFER cycles: IF_Valid pulses with IF_Data = 0, Error = 1 until Reset; the next request is served normally.
